bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
- Controller that sequences a chain of cascaded decimal (0-9) BCD digit counters as a start/stop/lap stopwatch.
- Generates the count-enable tick from a clock prescaler and runs a small run/pause FSM.
- Ripples carries digit to digit and provides a lap-freeze display register.
- Sits between debounced front-panel pulses and the 7-segment display driver.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8).
- TICK_DIV, 100000, clk cycles per count tick (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start_stop  in  1  single-cycle pulse, toggles run/pause.
- clear  in  1  single-cycle pulse, returns to IDLE with a zero count.
- lap  in  1  single-cycle pulse, toggles display freeze.
- bcd_out  out  4*DIGITS  displayed value; digit 0 in [3:0].
- running  out  1  high in RUN.
- lap_active  out  1  display frozen at the lap snapshot.
- overflow  out  1  sticky; count passed all-9s.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all digits, prescaler, snapshot = 0.
  - bcd_out=0, running=0, lap_active=0, overflow=0.
  - Reset mid-run aborts immediately with no partial update.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSE
  - PAUSE --start_stop--> RUN
  - any state --clear--> IDLE
- clear priority: clear dominates start_stop and lap in the same cycle.
  - Zeroes digits, prescaler and snapshot.
  - Clears overflow and lap_active.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN, then wraps to 0.
  - tick = (state==RUN && presc==TICK_DIV-1).
  - Holds its value in PAUSE, so a resume continues the partial period.
  - Is 0 in IDLE.
- Count latency: the first increment occurs on the TICK_DIV-th rising edge after the edge that entered RUN.
- Digit update, on the edge where tick=1:
  - Digit 0 increments.
  - Digit i (i>0) increments iff digits 0..i-1 all equal 9.
  - Any digit at 9 that increments goes to 0.
  - Digits never hold values 10-15.
- Wrap-around: all digits 9 plus tick gives all 0 and sets overflow=1 (sticky until clear/rst). FSM stays in RUN.
- running=1 exactly while state==RUN. Registered, valid the cycle after the start_stop edge.
- Lap, accepted in RUN or PAUSE; ignored in IDLE:
  - lap_active=0: capture the live digits (value before any same-edge increment) into the snapshot; set lap_active.
  - lap_active=1: clear lap_active.
  - The live count continues in either case.
- bcd_out = lap_active ? snapshot : live digits. Combinational mux of registers.
- start_stop and lap in the same cycle: both take effect. The snapshot is the pre-edge live value.
- A pulse held high for N cycles is treated as N pulses. No edge detection inside the block.

Optional Feature:
- SATURATE_EN defined:
  - When all digits are 9 and tick=1, the count holds at all-9s.
  - overflow is set and the FSM goes to PAUSE, so running=0 next cycle.
  - A further start_stop re-enters RUN and saturates again on the next tick.
- SATURATE_EN undefined: wrap to 0 and keep running, as in Behaviour.

Test Plan (DIGITS=2, TICK_DIV=4):
1. Assert rst mid-cycle, then release -> bcd_out=0x00, running=0, overflow=0, lap_active=0 immediately, asynchronously.
2. start_stop pulse, then wait 40 cycles -> bcd_out=0x10, with the 0x09->0x10 carry observed at tick 10; running=1.
3. At 0x05 with presc=2, pulse start_stop, idle 20 cycles, pulse start_stop -> value stays 0x05 during PAUSE; 0x06 appears 2 cycles after resume.
4. lap at live 0x12 -> bcd_out frozen at 0x12 while the live count reaches 0x15; second lap -> bcd_out=0x15, lap_active=0.
5. Run to 0x99, then one more tick:
   - Without SATURATE_EN -> 0x00, overflow=1, running=1.
   - With SATURATE_EN -> 0x99, overflow=1, running=0.
6. In RUN at 0x37 with lap_active=1, assert clear+start_stop+lap in the same cycle -> IDLE, bcd_out=0x00, lap_active=0, overflow=0, running=0.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_ctrl_if
//   Front-panel / display bundle of the BCD stopwatch controller.
//
//   Signals
//     start_stop  panel -> ctrl  single-cycle pulse, toggles run/pause
//     clear       panel -> ctrl  single-cycle pulse, back to IDLE with zero count
//     lap         panel -> ctrl  single-cycle pulse, toggles display freeze
//     bcd_out     ctrl -> panel  displayed value, 4 bits per digit, digit 0 in [3:0]
//     running     ctrl -> panel  high while counting
//     lap_active  ctrl -> panel  display frozen at the lap snapshot
//     overflow    ctrl -> panel  sticky, count passed all-9s
//
//   Modports
//     master  the panel side (drives pulses, reads the display)
//     slave   the controller
// -----------------------------------------------------------------------------
interface bcd_stopwatch_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                start_stop;
   logic                clear;
   logic                lap;
   logic [4*DIGITS-1:0] bcd_out;
   logic                running;
   logic                lap_active;
   logic                overflow;

   modport master (
      output start_stop, clear, lap,
      input  bcd_out, running, lap_active, overflow
   );

   modport slave (
      input  start_stop, clear, lap,
      output bcd_out, running, lap_active, overflow
   );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//   Start/stop/lap stopwatch controller driving a chain of cascaded decimal
//   (0-9) BCD digit counters. A prescaler produces the count tick, a small
//   IDLE/RUN/PAUSE FSM gates it, carries ripple digit to digit, and a lap
//   register can freeze the displayed value while the live count continues.
//
//   Parameters
//     DIGITS    number of cascaded BCD digits (1..8)
//     TICK_DIV  clk cycles per count tick (>= 2)
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     sw    bcd_stopwatch_ctrl_if.slave (start_stop, clear, lap in;
//           bcd_out, running, lap_active, overflow out)
//
//   Build option
//     SATURATE_EN  when defined, a tick at all-9s holds the count at all-9s,
//                  sets overflow and drops to PAUSE; when undefined the count
//                  wraps to zero, sets overflow and keeps running.
// -----------------------------------------------------------------------------
module bcd_stopwatch_ctrl #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 100000
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_stopwatch_ctrl_if.slave  sw
);

   localparam int             PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t                 state;
   logic [PW-1:0]          presc;
   logic [DIGITS-1:0][3:0] digits;
   logic [DIGITS-1:0][3:0] snapshot;
   logic [DIGITS-1:0][3:0] digits_inc;
   logic                   all_nines;
   logic                   tick;
   logic                   running_q;
   logic                   lap_active_q;
   logic                   overflow_q;

   // Next count value if a tick lands this cycle. all_nines is the running
   // "every lower digit is 9" carry; after the loop it covers all digits.
   always_comb begin
      // NOTE: every combinational output gets a default before any condition,
      // so no path leaves it unassigned and no latch is inferred.
      digits_inc = digits;
      all_nines  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (all_nines)
            digits_inc[i] = (digits[i] == 4'd9) ? 4'd0 : digits[i] + 4'd1;
         all_nines = all_nines && (digits[i] == 4'd9);
      end
   end

   assign tick = (state == RUN) && (presc == PRESC_LAST);

   // FSM, prescaler, digit chain and lap register share one clocked process so
   // that clear can override everything in a single place.
   // NOTE: state is updated with non-blocking assignments only; every right-hand
   // side below sees the pre-edge value, which is what makes the lap snapshot
   // capture the count before a same-edge increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         presc        <= '0;
         digits       <= '0;
         snapshot     <= '0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else if (sw.clear) begin
         state        <= IDLE;
         presc        <= '0;
         digits       <= '0;
         snapshot     <= '0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         // Prescaler only advances in RUN; it holds through PAUSE so a resume
         // finishes the partially elapsed period.
         if (state == RUN)
            presc <= tick ? '0 : presc + 1'b1;

         case (state)
            IDLE: begin
               if (sw.start_stop) begin
                  state     <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (sw.start_stop) begin
                  state     <= PAUSE;
                  running_q <= 1'b0;
               end
            end
            PAUSE: begin
               if (sw.start_stop) begin
                  state     <= RUN;
                  running_q <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               running_q <= 1'b0;
            end
         endcase

         if (tick) begin
            if (all_nines) begin
               overflow_q <= 1'b1;
`ifdef SATURATE_EN
               // Hold at all-9s and stop; overrides the FSM update above.
               state     <= PAUSE;
               running_q <= 1'b0;
`else
               digits <= digits_inc;
`endif
            end else begin
               digits <= digits_inc;
            end
         end

         if (sw.lap && (state != IDLE)) begin
            if (!lap_active_q) begin
               snapshot     <= digits;
               lap_active_q <= 1'b1;
            end else begin
               lap_active_q <= 1'b0;
            end
         end
      end
   end

   assign sw.bcd_out    = lap_active_q ? snapshot : digits;
   assign sw.running    = running_q;
   assign sw.lap_active = lap_active_q;
   assign sw.overflow   = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_stopwatch_ctrl
//   Self-checking bench for bcd_stopwatch_ctrl with DIGITS=2, TICK_DIV=4:
//   asynchronous reset, a directed vector table for the run/pause/lap/clear/
//   overflow corner cases, then random panel pulses against an integer model.
// -----------------------------------------------------------------------------
module tb_bcd_stopwatch_ctrl;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 4;
   localparam int MAXV     = 10**DIGITS - 1;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) sw_if ();

   bcd_stopwatch_ctrl #(
      .DIGITS   (DIGITS),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw_if.slave)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [4*DIGITS-1:0] bcd,
                                input bit run, input bit la, input bit ov);
      check({tag, ".bcd_out"},    32'(sw_if.bcd_out),    32'(bcd));
      check({tag, ".running"},    32'(sw_if.running),    32'(run));
      check({tag, ".lap_active"}, 32'(sw_if.lap_active), 32'(la));
      check({tag, ".overflow"},   32'(sw_if.overflow),   32'(ov));
   endtask

   // Decimal integer to packed BCD digits.
   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int                  x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // ---------------- behavioural model: count held as a plain integer -------
   int m_mode, m_presc, m_count, m_snap;
   bit m_lap, m_ovf;

   task automatic model_reset();
      m_mode = M_IDLE; m_presc = 0; m_count = 0; m_snap = 0; m_lap = 0; m_ovf = 0;
   endtask

   task automatic model_step(input bit ss, input bit clr, input bit lp);
      bit tick;
      int pre_count;
      int cur_mode;
      if (clr) begin
         model_reset();
         return;
      end
      cur_mode  = m_mode;
      pre_count = m_count;
      tick      = (cur_mode == M_RUN) && (m_presc == TICK_DIV - 1);
      if (cur_mode == M_RUN) m_presc = (m_presc + 1) % TICK_DIV;
      if (ss) m_mode = (cur_mode == M_RUN) ? M_PAUSE : M_RUN;
      if (tick) begin
         if (m_count == MAXV) begin
            m_ovf = 1;
`ifdef SATURATE_EN
            m_mode = M_PAUSE;
`else
            m_count = 0;
`endif
         end else begin
            m_count = m_count + 1;
         end
      end
      if (lp && cur_mode != M_IDLE) begin
         if (!m_lap) begin
            m_snap = pre_count;
            m_lap  = 1;
         end else begin
            m_lap = 0;
         end
      end
   endtask

   // ---------------- directed vector table -----------------------------------
   // Each row: pulse the inputs for one clock edge, wait idle more edges,
   // then compare all four outputs.
   typedef struct {
      bit                  ss;
      bit                  clr;
      bit                  lp;
      int                  idle;
      logic [4*DIGITS-1:0] bcd;
      bit                  run;
      bit                  la;
      bit                  ov;
   } vec_t;

   vec_t vecs[$];

   initial begin
      sw_if.start_stop = 1'b0;
      sw_if.clear      = 1'b0;
      sw_if.lap        = 1'b0;
      rst              = 1'b1;

      // Carry 0x09 -> 0x10 at tick 10, running
      vecs.push_back('{1, 0, 0,   0, 8'h00, 1, 0, 0});
      vecs.push_back('{0, 0, 0,  35, 8'h09, 1, 0, 0});
      vecs.push_back('{0, 0, 0,   3, 8'h10, 1, 0, 0});
      // Pause at 0x05 with presc=2, resume finishes the partial period
      vecs.push_back('{0, 1, 0,   0, 8'h00, 0, 0, 0});
      vecs.push_back('{1, 0, 0,   0, 8'h00, 1, 0, 0});
      vecs.push_back('{0, 0, 0,  21, 8'h05, 1, 0, 0});
      vecs.push_back('{1, 0, 0,   0, 8'h05, 0, 0, 0});
      vecs.push_back('{0, 0, 0,  19, 8'h05, 0, 0, 0});
      vecs.push_back('{1, 0, 0,   0, 8'h05, 1, 0, 0});
      vecs.push_back('{0, 0, 0,   0, 8'h06, 1, 0, 0});
      // Lap freeze at 0x12, live reaches 0x15, release shows 0x15
      vecs.push_back('{0, 1, 0,   0, 8'h00, 0, 0, 0});
      vecs.push_back('{1, 0, 0,   0, 8'h00, 1, 0, 0});
      vecs.push_back('{0, 0, 0,  48, 8'h12, 1, 0, 0});
      vecs.push_back('{0, 0, 1,   0, 8'h12, 1, 1, 0});
      vecs.push_back('{0, 0, 0,  10, 8'h12, 1, 1, 0});
      vecs.push_back('{0, 0, 1,   0, 8'h15, 1, 0, 0});
      // Freeze again at 0x15, live runs to 0x37, then clear+start_stop+lap
      vecs.push_back('{0, 0, 1,   0, 8'h15, 1, 1, 0});
      vecs.push_back('{0, 0, 0,  85, 8'h15, 1, 1, 0});
      vecs.push_back('{1, 1, 1,   0, 8'h00, 0, 0, 0});
      // Run to 0x99 and one tick beyond
      vecs.push_back('{1, 0, 0,   0, 8'h00, 1, 0, 0});
      vecs.push_back('{0, 0, 0, 394, 8'h98, 1, 0, 0});
      vecs.push_back('{0, 0, 0,   0, 8'h99, 1, 0, 0});
`ifdef SATURATE_EN
      vecs.push_back('{0, 0, 0,   3, 8'h99, 0, 0, 1});
      vecs.push_back('{1, 0, 0,   4, 8'h99, 0, 0, 1});
`else
      vecs.push_back('{0, 0, 0,   3, 8'h00, 1, 0, 1});
      vecs.push_back('{1, 0, 0,   4, 8'h00, 0, 0, 1});
`endif
      vecs.push_back('{0, 1, 0,   0, 8'h00, 0, 0, 0});

      // ---------------- reset, then asynchronous reset mid-run -------------
      repeat (2) @(negedge clk);
      check_outputs("reset", '0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      check_outputs("post_reset", '0, 0, 0, 0);

      sw_if.start_stop = 1'b1;
      @(negedge clk);
      sw_if.start_stop = 1'b0;
      repeat (10) @(negedge clk);
      check_outputs("pre_async_rst", 8'h02, 1, 0, 0);
      #1 rst = 1'b1;
      #1 check_outputs("async_rst", '0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_outputs("after_async_rst", '0, 0, 0, 0);

      // ---------------- directed table --------------------------------------
      foreach (vecs[k]) begin
         sw_if.start_stop = vecs[k].ss;
         sw_if.clear      = vecs[k].clr;
         sw_if.lap        = vecs[k].lp;
         @(negedge clk);
         sw_if.start_stop = 1'b0;
         sw_if.clear      = 1'b0;
         sw_if.lap        = 1'b0;
         repeat (vecs[k].idle) @(negedge clk);
         check_outputs($sformatf("vec%0d", k), vecs[k].bcd, vecs[k].run, vecs[k].la, vecs[k].ov);
      end

      // ---------------- random pulses against the model ---------------------
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      for (int c = 0; c < 4000; c++) begin
         bit ss, clr, lp;
         check_outputs($sformatf("rand%0d", c), to_bcd(m_lap ? m_snap : m_count),
                       m_mode == M_RUN, m_lap, m_ovf);
         ss  = ($urandom_range(0, 39)  == 0);
         clr = ($urandom_range(0, 599) == 0);
         lp  = ($urandom_range(0, 24)  == 0);
         sw_if.start_stop = ss;
         sw_if.clear      = clr;
         sw_if.lap        = lp;
         model_step(ss, clr, lp);
         @(negedge clk);
      end
      check_outputs("rand_end", to_bcd(m_lap ? m_snap : m_count),
                    m_mode == M_RUN, m_lap, m_ovf);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
